// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the digit-serial BCD adder/subtractor.
package bcd_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;
   localparam logic [3:0]  BCD_ADJ = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit add/subtract slice; subtraction uses the nines complement of b.
module bcd_digit_addsub
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       sub,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] b_eff_c;
   logic [4:0] t_c;

   always_comb begin
      b_eff_c = sub ? (BCD_MAX - b) : b;
      t_c     = {1'b0, a} + {1'b0, b_eff_c} + 5'(cin);
      if (t_c > 5'(BCD_MAX)) begin
         s    = t_c[3:0] + BCD_ADJ;
         cout = 1'b1;
      end else begin
         s    = t_c[3:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract with sign-magnitude result and valid/ready on both sides.
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int unsigned NDIGITS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   op_sub,
   input  logic [4*NDIGITS-1:0]   a,
   input  logic [4*NDIGITS-1:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NDIGITS-1:0]   result,
   output logic                   cout,
   output logic                   neg,
   output logic                   err
);

   localparam int unsigned W    = NDIGITS * DIGIT_W;
   localparam int unsigned IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NDIGITS - 1);

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            op_q;
   logic            carry_q;
   logic [IDXW-1:0] idx;

   logic [3:0]      dig_a_c;
   logic [3:0]      dig_b_c;
   logic [3:0]      dig_s_c;
   logic            dig_sub_c;
   logic            dig_cout_c;
   logic            bad_c;

   // FIX reuses the slice as 0 - result[idx] to form the tens complement
   always_comb begin
      if (state == FIX) begin
         dig_a_c   = 4'd0;
         dig_b_c   = result[int'(idx)*DIGIT_W +: DIGIT_W];
         dig_sub_c = 1'b1;
      end else begin
         dig_a_c   = a_q[int'(idx)*DIGIT_W +: DIGIT_W];
         dig_b_c   = b_q[int'(idx)*DIGIT_W +: DIGIT_W];
         dig_sub_c = op_q;
      end
   end

   always_comb begin
      bad_c = 1'b0;
      for (int i = 0; i < int'(NDIGITS); i++) begin
         if ((a[i*DIGIT_W +: DIGIT_W] > BCD_MAX) || (b[i*DIGIT_W +: DIGIT_W] > BCD_MAX))
            bad_c = 1'b1;
      end
   end

   bcd_digit_addsub u_digit (
      .a    (dig_a_c),
      .b    (dig_b_c),
      .cin  (carry_q),
      .sub  (dig_sub_c),
      .s    (dig_s_c),
      .cout (dig_cout_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 1'b0;
         carry_q   <= 1'b0;
         idx       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
         neg       <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  op_q     <= op_sub;
                  carry_q  <= op_sub;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  result   <= '0;
                  cout     <= 1'b0;
                  neg      <= 1'b0;
                  err      <= bad_c;
                  state    <= bad_c ? DONE : RUN;
               end
            end
            RUN: begin
               result[int'(idx)*DIGIT_W +: DIGIT_W] <= dig_s_c;
               carry_q <= dig_cout_c;
               idx     <= idx + IDXW'(1);
               if (idx == LAST) begin
                  if (!op_q) begin
                     cout      <= dig_cout_c;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else if (dig_cout_c) begin
                     neg       <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     idx     <= '0;
                     carry_q <= 1'b1;
                     state   <= FIX;
                  end
               end
            end
            FIX: begin
               result[int'(idx)*DIGIT_W +: DIGIT_W] <= dig_s_c;
               carry_q <= dig_cout_c;
               idx     <= idx + IDXW'(1);
               if (idx == LAST) begin
                  neg       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // invalid-input path arrives with out_valid low and raises it here
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub with NDIGITS=4.
module tb_bcd_serial_addsub;

   localparam int unsigned ND = 4;
   localparam int unsigned W  = 4 * ND;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          op_sub;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          cout;
   logic          neg;
   logic          err;

   typedef struct packed {
      logic [W-1:0] result;
      logic         cout;
      logic         neg;
      logic         err;
      logic [7:0]   lat;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   bcd_serial_addsub #(.NDIGITS(ND)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .neg       (neg),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      int n = 0;
      for (int i = ND - 1; i >= 0; i--) n = n * 10 + int'(v[i*4 +: 4]);
      return n;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int n);
      logic [W-1:0] v = '0;
      for (int i = 0; i < ND; i++) begin
         v[i*4 +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return v;
   endfunction

   function automatic exp_t model(input logic op, input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      int   x = bcd2int(av);
      int   y = bcd2int(bv);
      e = '0;
      if (!op) begin
         e.result = int2bcd((x + y) % 10000);
         e.cout   = (x + y) >= 10000;
         e.lat    = 8'(ND);
      end else if (x >= y) begin
         e.result = int2bcd(x - y);
         e.lat    = 8'(ND);
      end else begin
         e.result = int2bcd(y - x);
         e.neg    = 1'b1;
         e.lat    = 8'(2 * ND);
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < ND; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   task automatic send(input logic op, input logic [W-1:0] av, input logic [W-1:0] bv);
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      op_sub   = op;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_op(input logic [W-1:0] r, input logic c, input logic n,
                            input logic e, input int lat);
      exp_t x;
      x.result = r;
      x.cout   = c;
      x.neg    = n;
      x.err    = e;
      x.lat    = 8'(lat);
      sb.push_back(x);
   endtask

   // wait for out_valid (bounded), then compare against the scoreboard head
   task automatic wait_check(input string tag);
      int   lat = 0;
      exp_t x;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 40);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      if (sb.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         x = sb.pop_front();
         check({tag, "_latency"}, 32'(lat), 32'(x.lat));
         check({tag, "_result"}, 32'(result), 32'(x.result));
         check({tag, "_cout"}, 32'(cout), 32'(x.cout));
         check({tag, "_neg"}, 32'(neg), 32'(x.neg));
         check({tag, "_err"}, 32'(err), 32'(x.err));
         check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      end
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_model(input string tag, input logic op, input logic [W-1:0] av,
                            input logic [W-1:0] bv);
      sb.push_back(model(op, av, bv));
      send(op, av, bv);
      wait_check(tag);
      handshake(tag);
   endtask

   initial begin
      logic [W-1:0] hold_r;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_sub    = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", {29'd0, cout, neg, err}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      expect_op(16'h0000, 1'b1, 1'b0, 1'b0, 4);
      send(1'b0, 16'h1234, 16'h8766);
      wait_check("add_1234_8766");
      handshake("add_1234_8766");

      expect_op(16'h3766, 1'b0, 1'b0, 1'b0, 4);
      send(1'b1, 16'h5000, 16'h1234);
      wait_check("sub_5000_1234");
      handshake("sub_5000_1234");

      expect_op(16'h3766, 1'b0, 1'b1, 1'b0, 8);
      send(1'b1, 16'h1234, 16'h5000);
      wait_check("sub_1234_5000");
      handshake("sub_1234_5000");

      expect_op(16'h0000, 1'b0, 1'b0, 1'b0, 4);
      send(1'b1, 16'h4321, 16'h4321);
      wait_check("sub_equal");
      handshake("sub_equal");

      expect_op(16'h9998, 1'b1, 1'b0, 1'b0, 4);
      send(1'b0, 16'h9999, 16'h9999);
      wait_check("add_9999_9999");
      handshake("add_9999_9999");

      expect_op(16'h0000, 1'b0, 1'b0, 1'b0, 4);
      send(1'b0, 16'h0000, 16'h0000);
      wait_check("add_zero");
      handshake("add_zero");

      expect_op(16'h0000, 1'b0, 1'b0, 1'b1, 1);
      send(1'b0, 16'h12A4, 16'h0001);
      wait_check("invalid_a");
      handshake("invalid_a");

      expect_op(16'h0000, 1'b0, 1'b0, 1'b1, 1);
      send(1'b1, 16'h0001, 16'hF000);
      wait_check("invalid_b");
      handshake("invalid_b");

      // backpressure: outputs frozen, inputs ignored while out_ready is low
      expect_op(16'h0864, 1'b0, 1'b1, 1'b0, 8);
      send(1'b1, 16'h0123, 16'h0987);
      wait_check("bp");
      hold_r = result;
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         a        = 16'h5555;
         b        = 16'h1111;
         op_sub   = 1'b0;
         @(posedge clk);
         #1;
         check("bp_hold_out_valid", 32'(out_valid), 32'd1);
         check("bp_hold_result", 32'(result), 32'(hold_r));
         check("bp_hold_flags", {29'd0, cout, neg, err}, 32'b010);
         check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      handshake("bp");
      expect_op(16'h6666, 1'b0, 1'b0, 1'b0, 4);
      send(1'b0, 16'h5555, 16'h1111);
      wait_check("bp_next");
      handshake("bp_next");

      // asynchronous reset while RUN is at digit 2
      send(1'b0, 16'h1234, 16'h1111);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_result", 32'(result), 32'd0);
      check("arst_flags", {29'd0, cout, neg, err}, 32'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expect_op(16'h2345, 1'b0, 1'b0, 1'b0, 4);
      send(1'b0, 16'h1234, 16'h1111);
      wait_check("after_arst");
      handshake("after_arst");

      for (int i = 0; i < 8; i++) begin
         logic         op_r = 1'($urandom_range(0, 1));
         logic [W-1:0] ra   = rand_bcd();
         logic [W-1:0] rb   = rand_bcd();
         run_model("random", op_r, ra, rb);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
